// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for an N-stage in-order pipeline. It drives the
// per-stage register enables and bubble strobes, and tracks a valid bit per stage.
module pipeline_stall_ctrl #(
  parameter int STAGES      = 5,
  parameter int EXE_IDX     = 2,
  parameter int FLUSH_DEPTH = 1,
  parameter int MC_W        = 6,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              load_use_hazard,
  input  logic              mc_start,
  input  logic [MC_W-1:0]   mc_cycles,
  input  logic              flush_req,
  output logic [STAGES-1:0] stage_ena,
  output logic [STAGES-1:0] stage_bubble,
  output logic [STAGES-1:0] stage_valid,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

  mc_state_t         mc_state;
  logic [MC_W-1:0]   mc_cnt;
  logic              mc_done;
  logic              flush_pend;
  logic [STAGES-1:0] valid_q;

  logic              launch;
  logic              hold;
  logic              flush_eff;
  logic              load_use;
  logic              exe_advance;
  logic [STAGES-1:0] ena_n;
  logic [STAGES-1:0] bub_n;

  // Priority: multi-cycle hold, then flush, then load-use interlock.
  always_comb begin
    launch    = (mc_state == IDLE) && ena && mc_start && valid_q[EXE_IDX] &&
                (mc_cycles != '0) && !mc_done;
    hold      = launch || (mc_state == BUSY);
    flush_eff = (flush_req || flush_pend) && !hold && ena;
    load_use  = load_use_hazard && valid_q[1] && !hold;
    ena_n     = '0;
    bub_n     = '0;
    if (reset && ena) begin
      ena_n = '1;
      if (hold) begin
        for (int i = 0; i <= EXE_IDX; i++) ena_n[i] = 1'b0;
        bub_n[EXE_IDX+1] = 1'b1;
      end else if (flush_eff) begin
        for (int i = 1; i <= FLUSH_DEPTH; i++) bub_n[i] = 1'b1;
      end else if (load_use) begin
        for (int i = 0; i < EXE_IDX; i++) ena_n[i] = 1'b0;
        bub_n[EXE_IDX] = 1'b1;
      end
    end
  end

  assign stage_ena    = ena_n;
  assign stage_bubble = bub_n;
  assign mc_busy      = reset && hold;
  assign stage_valid  = valid_q;
  assign exe_advance  = ena_n[EXE_IDX+1] && !bub_n[EXE_IDX+1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      if (ena_n[0]) valid_q[0] <= 1'b1;
      for (int i = 1; i < STAGES; i++)
        if (ena_n[i]) valid_q[i] <= bub_n[i] ? 1'b0 : valid_q[i-1];
    end
  end

  // mc_done blocks a relaunch of the instruction that just finished its hold
  // until it has moved past the execute register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mc_state <= IDLE;
      mc_cnt   <= '0;
      mc_done  <= 1'b0;
    end else if (ena) begin
      case (mc_state)
        IDLE: begin
          if (launch) begin
            mc_cnt <= mc_cycles - MC_W'(1);
            if (mc_cycles == MC_W'(1)) mc_done <= 1'b1;
            else mc_state <= BUSY;
          end
        end
        BUSY: begin
          mc_cnt <= mc_cnt - MC_W'(1);
          if (mc_cnt == MC_W'(1)) begin
            mc_state <= IDLE;
            mc_done  <= 1'b1;
          end
        end
        default: mc_state <= IDLE;
      endcase
      if (exe_advance) mc_done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_pend <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      flush_pend <= flush_eff ? 1'b0 : (flush_pend || flush_req);
      if (ena && !ena_n[0] && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: per-cycle expectations go through a
// scoreboard queue; valid bits and stall count follow a small reference model.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic       load_use_hazard;
  logic       mc_start;
  logic [5:0] mc_cycles;
  logic       flush_req;
  logic [4:0] stage_ena;
  logic [4:0] stage_bubble;
  logic [4:0] stage_valid;
  logic       mc_busy;
  logic [5:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [4:0] se;
    logic [4:0] bub;
    logic       busy;
    logic [4:0] valid;
    logic [5:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] exp_valid = '0;
  logic [5:0] exp_cnt   = '0;

  pipeline_stall_ctrl #(.CNT_W(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .ena            (ena),
    .load_use_hazard(load_use_hazard),
    .mc_start       (mc_start),
    .mc_cycles      (mc_cycles),
    .flush_req      (flush_req),
    .stage_ena      (stage_ena),
    .stage_bubble   (stage_bubble),
    .stage_valid    (stage_valid),
    .mc_busy        (mc_busy),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_head();
    exp_t x;
    x = sb.pop_front();
    checks++;
    assert (stage_ena === x.se) else begin
      failures++;
      $error("FAIL %s stage_ena got=%b exp=%b", x.tag, stage_ena, x.se);
    end
    checks++;
    assert (stage_bubble === x.bub) else begin
      failures++;
      $error("FAIL %s stage_bubble got=%b exp=%b", x.tag, stage_bubble, x.bub);
    end
    checks++;
    assert (mc_busy === x.busy) else begin
      failures++;
      $error("FAIL %s mc_busy got=%b exp=%b", x.tag, mc_busy, x.busy);
    end
    checks++;
    assert (stage_valid === x.valid) else begin
      failures++;
      $error("FAIL %s stage_valid got=%b exp=%b", x.tag, stage_valid, x.valid);
    end
    checks++;
    assert (stall_cnt === x.cnt) else begin
      failures++;
      $error("FAIL %s stall_cnt got=%0d exp=%0d", x.tag, stall_cnt, x.cnt);
    end
  endtask

  // One clock cycle: drive inputs, expect the combinational outputs, then
  // advance the reference valid/stall model using the expected strobes.
  task automatic cyc(input string tag, input logic e, input logic lu,
                     input logic ms, input logic [5:0] mcc, input logic fr,
                     input logic [4:0] xse, input logic [4:0] xbub,
                     input logic xbusy);
    exp_t       x;
    logic [4:0] nv;
    ena             = e;
    load_use_hazard = lu;
    mc_start        = ms;
    mc_cycles       = mcc;
    flush_req       = fr;
    x.tag   = tag;
    x.se    = xse;
    x.bub   = xbub;
    x.busy  = xbusy;
    x.valid = exp_valid;
    x.cnt   = exp_cnt;
    sb.push_back(x);
    @(negedge clk);
    check_head();
    if (reset && e) begin
      if (!xse[0] && exp_cnt != 6'h3f) exp_cnt = exp_cnt + 6'd1;
      nv = exp_valid;
      if (xse[0]) nv[0] = 1'b1;
      for (int i = 1; i < 5; i++)
        if (xse[i]) nv[i] = xbub[i] ? 1'b0 : exp_valid[i-1];
      exp_valid = nv;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle", 1, 0, 0, 6'd0, 0, 5'b11111, 5'b00000, 0);
  endtask

  task automatic hold(input string tag, input logic ms, input logic [5:0] mcc,
                      input logic fr);
    cyc(tag, 1, 0, ms, mcc, fr, 5'b11000, 5'b01000, 1);
  endtask

  initial begin
    reset = 1'b0;
    ena = 1'b1; load_use_hazard = 1'b0; mc_start = 1'b0; mc_cycles = '0; flush_req = 1'b0;

    // outputs forced low while reset is held, even with ena=1
    cyc("in_reset", 1, 0, 0, 6'd0, 0, 5'b00000, 5'b00000, 0);
    cyc("in_reset", 1, 0, 0, 6'd0, 0, 5'b00000, 5'b00000, 0);
    reset = 1'b1;

    // fill: valid walks 00001 .. 11111
    for (int i = 0; i < 6; i++) cyc("fill", 1, 0, 0, 6'd0, 0, 5'b11111, 5'b00000, 0);

    // load-use interlock
    cyc("load_use", 1, 1, 0, 6'd0, 0, 5'b11100, 5'b00100, 0);
    idle(4);

    // 4-cycle op; mc_start stays high on the release cycle without relaunch
    hold("mc4_launch", 1, 6'd4, 0);
    for (int i = 0; i < 3; i++) hold("mc4_hold", 1, 6'd4, 0);
    cyc("mc4_release", 1, 0, 1, 6'd4, 0, 5'b11111, 5'b00000, 0);
    idle(1);

    // edge lengths 0 and 1
    cyc("mc0_nohold", 1, 0, 1, 6'd0, 0, 5'b11111, 5'b00000, 0);
    hold("mc1_hold", 1, 6'd1, 0);
    cyc("mc1_release", 1, 0, 1, 6'd1, 0, 5'b11111, 5'b00000, 0);
    idle(1);

    // direct flush wins over load-use; next hazard ignored since valid[1]=0
    cyc("flush_lu", 1, 1, 0, 6'd0, 1, 5'b11111, 5'b00010, 0);
    cyc("lu_invalid", 1, 1, 0, 6'd0, 0, 5'b11111, 5'b00000, 0);
    idle(1);

    // flush while frozen becomes pending, then applies
    cyc("frz_flush", 0, 0, 0, 6'd0, 1, 5'b00000, 5'b00000, 0);
    cyc("pend_apply", 1, 0, 0, 6'd0, 0, 5'b11111, 5'b00010, 0);
    cyc("pend_clear", 1, 0, 0, 6'd0, 0, 5'b11111, 5'b00000, 0);
    idle(4);

    // flush during a 4-cycle hold waits for the hold to end
    hold("fh_launch", 1, 6'd4, 0);
    hold("fh_req", 1, 6'd4, 1);
    hold("fh_hold", 1, 6'd4, 0);
    hold("fh_hold", 1, 6'd4, 0);
    cyc("fh_apply", 1, 0, 0, 6'd0, 0, 5'b11111, 5'b00010, 0);
    cyc("fh_cleared", 1, 0, 0, 6'd0, 0, 5'b11111, 5'b00000, 0);
    idle(4);

    // 5-cycle op frozen at mc_cnt=2; mc_cycles changes mid-op are ignored
    hold("frz_launch", 1, 6'd5, 0);
    hold("frz_hold", 1, 6'd2, 0);
    hold("frz_hold", 1, 6'd2, 0);
    for (int i = 0; i < 3; i++) cyc("frz_off", 0, 0, 1, 6'd2, 0, 5'b00000, 5'b00000, 1);
    hold("frz_resume", 1, 6'd2, 0);
    hold("frz_resume", 1, 6'd2, 0);
    cyc("frz_release", 1, 0, 1, 6'd2, 0, 5'b11111, 5'b00000, 0);
    idle(4);

    // 63-cycle op drives the 6-bit stall counter into saturation
    for (int i = 0; i < 63; i++) hold("mc63_hold", 1, 6'd63, 0);
    cyc("mc63_release", 1, 0, 1, 6'd63, 0, 5'b11111, 5'b00000, 0);
    idle(4);

    // reset mid-hold with a flush pending
    hold("rst_launch", 1, 6'd10, 0);
    hold("rst_flushreq", 1, 6'd10, 1);
    reset = 1'b0;
    #1;
    checks++;
    assert (stage_ena === 5'b00000) else begin
      failures++;
      $error("FAIL async_rst stage_ena got=%b exp=%b", stage_ena, 5'b00000);
    end
    checks++;
    assert (mc_busy === 1'b0) else begin
      failures++;
      $error("FAIL async_rst mc_busy got=%b exp=%b", mc_busy, 1'b0);
    end
    checks++;
    assert (stage_valid === 5'b00000) else begin
      failures++;
      $error("FAIL async_rst stage_valid got=%b exp=%b", stage_valid, 5'b00000);
    end
    checks++;
    assert (stall_cnt === 6'd0) else begin
      failures++;
      $error("FAIL async_rst stall_cnt got=%0d exp=%0d", stall_cnt, 0);
    end
    exp_valid = '0;
    exp_cnt   = '0;
    cyc("held_rst", 1, 0, 1, 6'd10, 0, 5'b00000, 5'b00000, 0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) cyc("refill", 1, 0, 0, 6'd0, 0, 5'b11111, 5'b00000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
